// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers host ALU commands in a small FIFO, issues them one at
// a time to alu_top with a single-cycle start pulse, waits for a rising edge on
// done (or gives up after TIMEOUT cycles) and returns the result with a tag on a
// valid/ready response port.
`timescale 1ns/1ps

module alu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic             alu_done,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [2:0]       fifo_op_r [FIFO_DEPTH];
    logic [7:0]       fifo_a_r  [FIFO_DEPTH];
    logic [7:0]       fifo_b_r  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    logic             push_s;
    logic             pop_s;
    logic             done_q_r;
    logic             done_rise_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;
    logic             cap_done_s;
    logic             cap_tmo_s;
    logic             rsp_ack_s;

    // cmd_ready is a registered !full, so a same-cycle pop never frees a slot early
    assign push_s      = cmd_valid & cmd_ready;
    assign done_rise_s = alu_done & ~done_q_r;
    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO payload storage; stale entries are harmless because count gates reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_op_r[wr_ptr_r] <= cmd_op;
            fifo_a_r[wr_ptr_r]  <= cmd_a;
            fifo_b_r[wr_ptr_r]  <= cmd_b;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            count_r   <= CNT_W'(0);
            cmd_ready <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r   <= count_next_s;
            cmd_ready <= (count_next_s != FULL_CNT);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle control strobes; done beats timeout in WAIT
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        cap_done_s   = 1'b0;
        cap_tmo_s    = 1'b0;
        rsp_ack_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    cap_done_s   = 1'b1;
                    state_next_s = ST_RESP;
                end else if (tmo_hit_s) begin
                    cap_tmo_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_ack_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Done history for edge detection and the WAIT-cycle timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q_r  <= 1'b0;
            tmo_cnt_r <= TMO_W'(0);
        end else begin
            done_q_r <= alu_done;
            if (state_r == ST_ISSUE) begin
                tmo_cnt_r <= TMO_W'(0);
            end else if (state_r == ST_WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Registered ALU request and host response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_start   <= 1'b0;
            alu_op      <= 3'd0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 16'd0;
            rsp_op      <= 3'd0;
            rsp_tag     <= TAG_W'(0);
            rsp_timeout <= 1'b0;
        end else begin
            alu_start <= (state_next_s == ST_ISSUE);
            if (pop_s) begin
                alu_op <= fifo_op_r[rd_ptr_r];
                alu_a  <= fifo_a_r[rd_ptr_r];
                alu_b  <= fifo_b_r[rd_ptr_r];
            end
            if (cap_done_s) begin
                rsp_valid   <= 1'b1;
                rsp_result  <= alu_result;
                rsp_op      <= alu_op;
                rsp_timeout <= 1'b0;
            end else if (cap_tmo_s) begin
                rsp_valid   <= 1'b1;
                rsp_result  <= 16'd0;
                rsp_op      <= alu_op;
                rsp_timeout <= 1'b1;
            end else if (rsp_ack_s) begin
                rsp_valid <= 1'b0;
                rsp_tag   <= rsp_tag + TAG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed commands, a behavioural alu_top responder,
// and a scoreboard queue drained by an independent response monitor.
`timescale 1ns/1ps

module tb_alu_cmd_issuer;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic             alu_start;
    logic [2:0]       alu_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_done;
    logic [15:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic [2:0]       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;

    alu_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- alu_top behavioural model ----------------
    int          alu_delay = 3;
    bit          alu_mute  = 1'b0;
    int          alu_cnt;
    logic [15:0] alu_pend;

    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] sp;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        sp = sa * sb;
        case (op)
            3'b000:  return {8'h00, a} + {8'h00, b};
            3'b001:  return {8'h00, a} - {8'h00, b};
            3'b010:  return sp;
            3'b011:  return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
            3'b100:  return {8'h00, a & b};
            3'b101:  return {8'h00, a | b};
            3'b110:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done   <= 1'b0;
            alu_result <= 16'h0000;
            alu_cnt    <= 0;
            alu_pend   <= 16'h0000;
        end else begin
            alu_done   <= 1'b0;
            alu_result <= 16'h0000;
            if (alu_start) begin
                alu_cnt  <= alu_mute ? 0 : alu_delay;
                alu_pend <= alu_calc(alu_op, alu_a, alu_b);
            end else if (alu_cnt > 0) begin
                alu_cnt <= alu_cnt - 1;
                if (alu_cnt == 1) begin
                    alu_done   <= 1'b1;
                    alu_result <= alu_pend;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0]      res;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             to;
    } exp_t;

    exp_t             sb_q[$];
    logic [TAG_W-1:0] exp_tag = '0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               start_cnt = 0;
    logic             prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the oldest expectation whenever a response is handed over
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (alu_start) begin
                start_cnt++;
                chk("start_one_cycle", 32'(prev_start), 32'd0);
            end
            prev_start = alu_start;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_result",  32'(rsp_result),  32'(e.res));
                    chk("rsp_op",      32'(rsp_op),      32'(e.op));
                    chk("rsp_tag",     32'(rsp_tag),     32'(e.tag));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] res, input logic to, output bit acc);
        exp_t e;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        acc = cmd_ready;
        if (acc) begin
            e.res = res;
            e.op  = op;
            e.tag = exp_tag;
            e.to  = to;
            sb_q.push_back(e);
            exp_tag++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, 32'({alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_op, rsp_tag, rsp_timeout}),
            32'd0);
        chk({name, "_result"}, 32'(rsp_result), 32'd0);
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb_q.delete();
        exp_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (!alu_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(alu_start), 32'd1);
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        bit          acc;
        int          s0;
        int          k;
        logic [2:0]  t3_op  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b000};
        logic [7:0]  t3_a   [6] = '{8'd1, 8'd9, 8'hF0, 8'hF0, 8'hAA, 8'd7};
        logic [7:0]  t3_b   [6] = '{8'd2, 8'd4, 8'h3C, 8'h0F, 8'hFF, 8'd7};
        logic [15:0] t3_res [6] = '{16'd3, 16'd5, 16'h0030, 16'h00FF, 16'h0055, 16'd14};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        rsp_ready = 1'b1;
        #12;
        chk_reset_outs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: ADD with start-pulse latency
        s0 = start_cnt;
        push(3'b000, 8'd25, 8'd17, 16'd42, 1'b0, acc);
        chk("t1_accept", 32'(acc), 32'd1);
        @(negedge clk);
        chk("t1_start_before_issue", 32'(alu_start), 32'd0);
        @(negedge clk);
        chk("t1_start_in_issue", 32'(alu_start), 32'd1);
        chk("t1_issue_bus", 32'({alu_op, alu_a, alu_b}), 32'({3'b000, 8'd25, 8'd17}));
        @(posedge clk);
        #1;
        drain(100);
        chk("t1_start_count", 32'(start_cnt - s0), 32'd1);

        // 2: signed MUL and divide-by-zero passthrough
        do_reset();
        push(3'b010, 8'hF6, 8'h05, 16'hFFCE, 1'b0, acc);
        drain(100);
        push(3'b011, 8'd10, 8'd0, 16'hFFFF, 1'b0, acc);
        drain(100);

        // 3: fill the FIFO while the response port is stalled
        do_reset();
        rsp_ready = 1'b0;
        s0 = start_cnt;
        for (int i = 0; i < 6; i++) begin
            push(t3_op[i], t3_a[i], t3_b[i], t3_res[i], 1'b0, acc);
            chk($sformatf("t3_accept_%0d", i), 32'(acc), (i < 5) ? 32'd1 : 32'd0);
        end

        // 4: backpressure holds the first response and blocks further issue
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid",  32'(rsp_valid), 32'd1);
            chk("t4_hold_fields", 32'({rsp_result, rsp_op, rsp_tag, rsp_timeout}),
                32'({16'd3, 3'b000, 4'd0, 1'b0}));
        end
        chk("t4_no_extra_start", 32'(start_cnt - s0), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain(600);

        // 5: timeout after 64 WAIT cycles, then a normal command
        alu_mute = 1'b1;
        push(3'b001, 8'd5, 8'd3, 16'd0, 1'b1, acc);
        wait_start("t5_start_seen");
        k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_timeout_latency", 32'(k), 32'd65);
        @(posedge clk);
        #1;
        drain(20);
        alu_mute = 1'b0;
        push(3'b001, 8'd9, 8'd4, 16'd5, 1'b0, acc);
        drain(100);

        // 6: asynchronous reset while waiting for done
        alu_delay = 20;
        push(3'b000, 8'd1, 8'd1, 16'd2, 1'b0, acc);
        wait_start("t6_start_seen");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb_q.delete();
        exp_tag = '0;
        #1;
        chk_reset_outs("t6_async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        alu_delay = 3;
        push(3'b100, 8'h0F, 8'h3C, 16'h000C, 1'b0, acc);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
